// File: rtl/kilit_pkg.sv
// Shared types and constants for the combination-lock sequential front-end.
package kilit_pkg;

  // Step-count and failure-count widths
  localparam int unsigned SAG_W  = 3;
  localparam int unsigned SOL_W  = 2;
  localparam int unsigned HATA_W = 2;

  // Default timing and policy constants
  localparam int unsigned ACIK_SURE_VARSAYILAN   = 16;
  localparam int unsigned KILIT_SURE_VARSAYILAN  = 64;
  localparam int unsigned MAX_HATA_VARSAYILAN    = 3;
  localparam int unsigned ZAMAN_ASIMI_VARSAYILAN = 256;

  // Controller states
  typedef enum logic [2:0] {
    BOSTA   = 3'd0,
    SAG     = 3'd1,
    SOL     = 3'd2,
    DENETLE = 3'd3,
    ACIK    = 3'd4,
    KILITLI = 3'd5
  } kilit_durum_t;

  // Timer width: enough bits to hold (largest duration - 1), never below one bit
  function automatic int unsigned sayac_genisligi(input int unsigned a,
                                                  input int unsigned b,
                                                  input int unsigned c);
    int unsigned en_buyuk;
    en_buyuk = a;
    if (b > en_buyuk) en_buyuk = b;
    if (c > en_buyuk) en_buyuk = c;
    if (en_buyuk < 2) en_buyuk = 2;
    return $clog2(en_buyuk);
  endfunction

endpackage

// File: rtl/kilit_zamanlayici.sv
// Loadable down-counter shared by the open, lockout and entry-timeout intervals.
// Loaded with (duration - 1); bitti is a registered one-cycle pulse raised when
// the count reaches zero, so the owner leaves its state exactly 'duration'
// cycles after the load edge.
module kilit_zamanlayici #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         yukle,
  input  logic [W-1:0] deger,
  output logic         bitti
);

  logic [W-1:0] sayac;

  // Count down towards zero, restarting on every load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sayac <= '0;
      bitti <= 1'b0;
    end else if (yukle) begin
      sayac <= deger;
      bitti <= (deger == '0);
    end else begin
      if (sayac != '0) begin
        sayac <= sayac - W'(1);
      end
      bitti <= (sayac == W'(1));
    end
  end

endmodule

// File: rtl/kilit_sirali_denetleyici.sv
// Sequential front-end of the combination lock: counts rotation detents, samples
// the checker verdict on 'onay', opens the door or records failures, and
// enforces a timed lockout after repeated failures.
module kilit_sirali_denetleyici
  import kilit_pkg::*;
#(
  parameter int unsigned ACIK_SURE   = ACIK_SURE_VARSAYILAN,
  parameter int unsigned KILIT_SURE  = KILIT_SURE_VARSAYILAN,
  parameter int unsigned MAX_HATA    = MAX_HATA_VARSAYILAN,
  parameter int unsigned ZAMAN_ASIMI = ZAMAN_ASIMI_VARSAYILAN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sag_darbe,
  input  logic              sol_darbe,
  input  logic              onay,
  input  logic              kilit_acik,
  output logic [SAG_W-1:0]  sag_adim,
  output logic [SOL_W-1:0]  sol_adim,
  output logic              kapi_acik,
  output logic              hata,
  output logic              kilitli,
  output logic [HATA_W-1:0] hata_sayisi
);

  localparam int unsigned SAYAC_W = sayac_genisligi(ACIK_SURE, KILIT_SURE, ZAMAN_ASIMI);

  localparam logic [SAG_W-1:0]   SAG_EN_BUYUK = '1;
  localparam logic [SOL_W-1:0]   SOL_EN_BUYUK = '1;
  localparam logic [HATA_W-1:0]  HATA_SINIR   = HATA_W'(MAX_HATA);
  localparam logic [SAYAC_W-1:0] ACIK_YUK     = SAYAC_W'(ACIK_SURE - 1);
  localparam logic [SAYAC_W-1:0] KILIT_YUK    = SAYAC_W'(KILIT_SURE - 1);
  localparam logic [SAYAC_W-1:0] ZAMAN_YUK    = SAYAC_W'(ZAMAN_ASIMI - 1);

  kilit_durum_t      durum_q, durum_d;
  logic [SAG_W-1:0]  sag_d;
  logic [SOL_W-1:0]  sol_d;
  logic [HATA_W-1:0] hata_sayisi_d;
  logic              hata_d;
  logic              hata_olay_c;
  logic              darbe_var_c;
  logic              yukle_c;
  logic [SAYAC_W-1:0] deger_c;
  logic              bitti;

  // Shared interval timer
  kilit_zamanlayici #(
    .W (SAYAC_W)
  ) u_zamanlayici (
    .clk   (clk),
    .rst   (rst),
    .yukle (yukle_c),
    .deger (deger_c),
    .bitti (bitti)
  );

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q     <= BOSTA;
      sag_adim    <= '0;
      sol_adim    <= '0;
      hata        <= 1'b0;
      hata_sayisi <= '0;
      kapi_acik   <= 1'b0;
      kilitli     <= 1'b0;
    end else begin
      durum_q     <= durum_d;
      sag_adim    <= sag_d;
      sol_adim    <= sol_d;
      hata        <= hata_d;
      hata_sayisi <= hata_sayisi_d;
      kapi_acik   <= (durum_d == ACIK);
      kilitli     <= (durum_d == KILITLI);
    end
  end

  // Next-state, count and failure logic; failure outranks onay, which outranks rotation
  always_comb begin
    durum_d       = durum_q;
    sag_d         = sag_adim;
    sol_d         = sol_adim;
    hata_d        = 1'b0;
    hata_sayisi_d = hata_sayisi;
    hata_olay_c   = 1'b0;

    case (durum_q)
      BOSTA: begin
        // Simultaneous pulses and onay are ignored while idle
        if (sag_darbe && !sol_darbe) begin
          durum_d = SAG;
          sag_d   = SAG_W'(1);
          sol_d   = '0;
        end else if (sol_darbe && !sag_darbe) begin
          durum_d = SOL;
          sag_d   = '0;
          sol_d   = SOL_W'(1);
        end
      end

      SAG: begin
        if ((sag_darbe && sol_darbe) || (sag_darbe && (sag_adim == SAG_EN_BUYUK))) begin
          hata_olay_c = 1'b1;
        end else if (onay) begin
          durum_d = DENETLE;
        end else if (sag_darbe) begin
          sag_d = sag_adim + SAG_W'(1);
        end else if (sol_darbe) begin
          durum_d = SOL;
          sol_d   = SOL_W'(1);
        end else if (bitti) begin
          durum_d = BOSTA;
          sag_d   = '0;
          sol_d   = '0;
        end
      end

      SOL: begin
        // Any right pulse after left steps began is an order violation
        if (sag_darbe || (sol_darbe && (sol_adim == SOL_EN_BUYUK))) begin
          hata_olay_c = 1'b1;
        end else if (onay) begin
          durum_d = DENETLE;
        end else if (sol_darbe) begin
          sol_d = sol_adim + SOL_W'(1);
        end else if (bitti) begin
          durum_d = BOSTA;
          sag_d   = '0;
          sol_d   = '0;
        end
      end

      DENETLE: begin
        if (kilit_acik) begin
          durum_d       = ACIK;
          hata_sayisi_d = '0;
        end else begin
          hata_olay_c = 1'b1;
        end
      end

      ACIK: begin
        if (bitti) begin
          durum_d = BOSTA;
          sag_d   = '0;
          sol_d   = '0;
        end
      end

      KILITLI: begin
        if (bitti) begin
          durum_d       = BOSTA;
          hata_sayisi_d = '0;
        end
      end

      default: begin
        durum_d = BOSTA;
        sag_d   = '0;
        sol_d   = '0;
      end
    endcase

    // Failed attempt: pulse hata, bump the count, clear steps, maybe lock out
    if (hata_olay_c) begin
      hata_d        = 1'b1;
      hata_sayisi_d = hata_sayisi + HATA_W'(1);
      sag_d         = '0;
      sol_d         = '0;
      durum_d       = (hata_sayisi_d == HATA_SINIR) ? KILITLI : BOSTA;
    end
  end

  // Timer reload on every state entry and on every input pulse during entry
  always_comb begin
    darbe_var_c = sag_darbe || sol_darbe || onay;
    yukle_c     = (durum_d != durum_q) ||
                  (((durum_q == SAG) || (durum_q == SOL)) && darbe_var_c);
    case (durum_d)
      ACIK:    deger_c = ACIK_YUK;
      KILITLI: deger_c = KILIT_YUK;
      default: deger_c = ZAMAN_YUK;
    endcase
  end

endmodule

// File: tb/tb_kilit_sirali_denetleyici.sv
// Directed bench for the combination-lock sequential front-end.
module tb_kilit_sirali_denetleyici;

  logic       clk;
  logic       rst;
  logic       sag_darbe;
  logic       sol_darbe;
  logic       onay;
  logic       kilit_acik;
  logic [2:0] sag_adim;
  logic [1:0] sol_adim;
  logic       kapi_acik;
  logic       hata;
  logic       kilitli;
  logic [1:0] hata_sayisi;

  int tests_run    = 0;
  int tests_failed = 0;

  // Checker model: the combination is right 3, left 2
  assign kilit_acik = (sag_adim == 3'd3) && (sol_adim == 2'd2);

  kilit_sirali_denetleyici dut (
    .clk         (clk),
    .rst         (rst),
    .sag_darbe   (sag_darbe),
    .sol_darbe   (sol_darbe),
    .onay        (onay),
    .kilit_acik  (kilit_acik),
    .sag_adim    (sag_adim),
    .sol_adim    (sol_adim),
    .kapi_acik   (kapi_acik),
    .hata        (hata),
    .kilitli     (kilitli),
    .hata_sayisi (hata_sayisi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one cycle of inputs starting at a negedge; returns at the next negedge
  task automatic darbe(input logic s, input logic l, input logic o);
    sag_darbe = s;
    sol_darbe = l;
    onay      = o;
    @(negedge clk);
    sag_darbe = 1'b0;
    sol_darbe = 1'b0;
    onay      = 1'b0;
  endtask

  // Enter s right steps, l left steps, then press onay
  task automatic gir(input int s, input int l);
    for (int i = 0; i < s; i++) darbe(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < l; i++) darbe(1'b0, 1'b1, 1'b0);
    darbe(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({sag_adim, sol_adim, kapi_acik, hata, kilitli, hata_sayisi} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0", {sag_adim, sol_adim, kapi_acik, hata, kilitli, hata_sayisi});
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({sag_adim, sol_adim, kapi_acik, hata, kilitli, hata_sayisi} !== 10'b0) begin
      tests_failed++;
      $display("FAIL post_reset_outputs: got %b expected 0", {sag_adim, sol_adim, kapi_acik, hata, kilitli, hata_sayisi});
    end
  endtask

  task automatic test_correct_entry();
    int cnt;
    for (int i = 0; i < 3; i++) darbe(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) darbe(1'b0, 1'b1, 1'b0);
    tests_run++;
    if ({sag_adim, sol_adim} !== 5'b011_10) begin
      tests_failed++;
      $display("FAIL entry_counts: got sag=%0d sol=%0d expected sag=3 sol=2", sag_adim, sol_adim);
    end
    darbe(1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({kapi_acik, hata} !== 2'b00) begin
      tests_failed++;
      $display("FAIL check_cycle: got kapi=%b hata=%b expected 0 0", kapi_acik, hata);
    end
    @(negedge clk);
    tests_run++;
    if ({kapi_acik, hata, kilitli, hata_sayisi} !== 5'b100_00) begin
      tests_failed++;
      $display("FAIL open_start: got kapi=%b hata=%b kilitli=%b hs=%0d expected 1 0 0 0", kapi_acik, hata, kilitli, hata_sayisi);
    end
    cnt = kapi_acik ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kapi_acik) cnt++;
      else break;
    end
    tests_run++;
    if (cnt != 16) begin
      tests_failed++;
      $display("FAIL open_length: got %0d cycles expected 16", cnt);
    end
    tests_run++;
    if ({sag_adim, sol_adim, hata_sayisi, kapi_acik} !== 8'b0) begin
      tests_failed++;
      $display("FAIL open_end: got sag=%0d sol=%0d hs=%0d kapi=%b expected all 0", sag_adim, sol_adim, hata_sayisi, kapi_acik);
    end
  endtask

  task automatic test_wrong_x3();
    int  cnt;
    logic ignored_ok;
    logic extra_hata;
    for (int k = 1; k <= 3; k++) begin
      gir(2, 1);
      tests_run++;
      if ({hata, kapi_acik} !== 2'b00) begin
        tests_failed++;
        $display("FAIL wrong_check_cycle_%0d: got hata=%b kapi=%b expected 0 0", k, hata, kapi_acik);
      end
      @(negedge clk);
      tests_run++;
      if (hata !== 1'b1 || hata_sayisi !== 2'(k) || kilitli !== (k == 3) || kapi_acik !== 1'b0) begin
        tests_failed++;
        $display("FAIL wrong_result_%0d: got hata=%b hs=%0d kilitli=%b kapi=%b expected 1 %0d %0d 0",
                 k, hata, hata_sayisi, kilitli, kapi_acik, k, (k == 3));
      end
      if (k < 3) begin
        @(negedge clk);
        tests_run++;
        if (hata !== 1'b0) begin
          tests_failed++;
          $display("FAIL wrong_pulse_width_%0d: got hata=%b expected 0", k, hata);
        end
      end
    end
    // Lockout: pulses are offered every cycle and must have no effect
    cnt        = kilitli ? 1 : 0;
    ignored_ok = 1'b1;
    extra_hata = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sag_darbe = (i % 2 == 0);
      onay      = (i % 2 == 1);
      @(negedge clk);
      sag_darbe = 1'b0;
      onay      = 1'b0;
      if (hata) extra_hata = 1'b1;
      if (sag_adim != 3'd0 || kapi_acik) ignored_ok = 1'b0;
      if (kilitli) cnt++;
      else break;
    end
    tests_run++;
    if (cnt != 64) begin
      tests_failed++;
      $display("FAIL lockout_length: got %0d cycles expected 64", cnt);
    end
    tests_run++;
    if (ignored_ok !== 1'b1 || extra_hata !== 1'b0) begin
      tests_failed++;
      $display("FAIL lockout_ignore: got ignored_ok=%b extra_hata=%b expected 1 0", ignored_ok, extra_hata);
    end
    tests_run++;
    if ({hata_sayisi, kilitli} !== 3'b000) begin
      tests_failed++;
      $display("FAIL lockout_end: got hs=%0d kilitli=%b expected 0 0", hata_sayisi, kilitli);
    end
  endtask

  task automatic test_idle_ignore();
    darbe(1'b1, 1'b1, 1'b0);
    tests_run++;
    if ({sag_adim, sol_adim, hata} !== 6'b0) begin
      tests_failed++;
      $display("FAIL idle_simultaneous: got sag=%0d sol=%0d hata=%b expected 0 0 0", sag_adim, sol_adim, hata);
    end
    darbe(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({kapi_acik, hata, hata_sayisi} !== 4'b0) begin
      tests_failed++;
      $display("FAIL idle_onay: got kapi=%b hata=%b hs=%0d expected 0 0 0", kapi_acik, hata, hata_sayisi);
    end
  endtask

  task automatic test_overflow();
    logic seq_ok;
    seq_ok = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      darbe(1'b1, 1'b0, 1'b0);
      if (sag_adim !== 3'(i) || hata !== 1'b0) seq_ok = 1'b0;
    end
    tests_run++;
    if (seq_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_count: got seq_ok=%b sag=%0d expected 1 7", seq_ok, sag_adim);
    end
    darbe(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (hata !== 1'b1 || hata_sayisi !== 2'd1 || sag_adim !== 3'd0 || kilitli !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_hata: got hata=%b hs=%0d sag=%0d kilitli=%b expected 1 1 0 0", hata, hata_sayisi, sag_adim, kilitli);
    end
    @(negedge clk);
    tests_run++;
    if (hata !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_pulse_width: got hata=%b expected 0", hata);
    end
  endtask

  task automatic test_order_violation();
    darbe(1'b1, 1'b0, 1'b0);
    darbe(1'b0, 1'b1, 1'b0);
    tests_run++;
    if ({sag_adim, sol_adim} !== 5'b001_01) begin
      tests_failed++;
      $display("FAIL order_counts: got sag=%0d sol=%0d expected 1 1", sag_adim, sol_adim);
    end
    darbe(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (hata !== 1'b1 || hata_sayisi !== 2'd2 || sag_adim !== 3'd0 || sol_adim !== 2'd0) begin
      tests_failed++;
      $display("FAIL order_hata: got hata=%b hs=%0d sag=%0d sol=%0d expected 1 2 0 0", hata, hata_sayisi, sag_adim, sol_adim);
    end
    @(negedge clk);
  endtask

  task automatic test_success_clears();
    tests_run++;
    if (hata_sayisi !== 2'd2) begin
      tests_failed++;
      $display("FAIL pre_success_count: got %0d expected 2", hata_sayisi);
    end
    test_correct_entry();
  endtask

  task automatic test_simultaneous();
    darbe(1'b1, 1'b0, 1'b0);
    darbe(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (hata !== 1'b1 || hata_sayisi !== 2'd1 || sag_adim !== 3'd0 || sol_adim !== 2'd0) begin
      tests_failed++;
      $display("FAIL simultaneous_hata: got hata=%b hs=%0d sag=%0d sol=%0d expected 1 1 0 0", hata, hata_sayisi, sag_adim, sol_adim);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic seen;
    seen = 1'b0;
    darbe(1'b1, 1'b0, 1'b0);
    darbe(1'b1, 1'b0, 1'b0);
    repeat (255) begin
      @(negedge clk);
      if (hata) seen = 1'b1;
    end
    tests_run++;
    if (sag_adim !== 3'd2) begin
      tests_failed++;
      $display("FAIL timeout_early: got sag=%0d after 255 idle cycles expected 2", sag_adim);
    end
    @(negedge clk);
    if (hata) seen = 1'b1;
    tests_run++;
    if ({sag_adim, sol_adim} !== 5'b0) begin
      tests_failed++;
      $display("FAIL timeout_clear: got sag=%0d sol=%0d after 256 idle cycles expected 0 0", sag_adim, sol_adim);
    end
    repeat (2) begin
      @(negedge clk);
      if (hata) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0 || hata_sayisi !== 2'd1) begin
      tests_failed++;
      $display("FAIL timeout_no_failure: got hata_seen=%b hs=%0d expected 0 1", seen, hata_sayisi);
    end
  endtask

  task automatic test_reset_mid_acik();
    gir(3, 2);
    repeat (6) @(negedge clk);
    tests_run++;
    if (kapi_acik !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_open_setup: got kapi=%b expected 1", kapi_acik);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({sag_adim, sol_adim, kapi_acik, hata, kilitli, hata_sayisi} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_open: got %b expected 0", {sag_adim, sol_adim, kapi_acik, hata, kilitli, hata_sayisi});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_correct_entry();
  endtask

  task automatic test_reset_mid_kilitli();
    for (int k = 0; k < 3; k++) begin
      gir(2, 1);
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (kilitli !== 1'b1 || hata_sayisi !== 2'd3) begin
      tests_failed++;
      $display("FAIL mid_lock_setup: got kilitli=%b hs=%0d expected 1 3", kilitli, hata_sayisi);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({sag_adim, sol_adim, kapi_acik, hata, kilitli, hata_sayisi} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_lock: got %b expected 0", {sag_adim, sol_adim, kapi_acik, hata, kilitli, hata_sayisi});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (kilitli !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_after_release: got kilitli=%b expected 0", kilitli);
    end
    test_correct_entry();
  endtask

  initial begin
    rst       = 1'b1;
    sag_darbe = 1'b0;
    sol_darbe = 1'b0;
    onay      = 1'b0;
    test_reset();
    test_correct_entry();
    test_wrong_x3();
    test_idle_ignore();
    test_overflow();
    test_order_violation();
    test_success_clears();
    test_simultaneous();
    test_timeout();
    test_reset_mid_acik();
    test_reset_mid_kilitli();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
